led_pwm_driver: RTL and testbench
=================================

Name: led_pwm_driver

Overview:
- Parametrised memory-mapped LED output block; successor to the fixed 24-LED latch driver.
- Per-LED on/off and blink-enable registers, global PWM brightness, programmable blink period, optional register readback.
- Sits behind the MemOrIO address decoder on the CPU clock, driving board LED pins.

Parameters:
- LED_COUNT, 24, number of LEDs driven; legal range 1..32.
- PWM_BITS, 8, width of the PWM counter and the DUTY register.
- CLK_DIV, 50000, CPU clocks per prescaler tick; must be >= 2.

Ports:
- iCpuClock  input  1  CPU clock; all state changes on its rising edge.
- iCpuReset  input  1  asynchronous, active-high reset.
- iDoLedWrite  input  1  write strobe from MemOrIO, sampled each rising edge.
- iDoLedRead  input  1  read strobe from MemOrIO.
- iLightAddress  input  3  register select.
- iLightDataToWrite  input  16  write data.
- oLightReadData  output  16  registered read data.
- oFpgaLights  output  LED_COUNT  registered LED pin drive, 1 = lit.

Behaviour:
- Register map:
  - 0 = ON[15:0]; 1 = ON[31:16].
  - 2 = BLINK[15:0]; 3 = BLINK[31:16].
  - 4 = DUTY[PWM_BITS-1:0].
  - 5 = HALF[15:0], blink half-period in prescaler ticks.
  - 6, 7 = reserved; writes ignored, reads return 0.
- Bits at index >= LED_COUNT: not stored; read back as 0. DUTY upper write bits are ignored.
- Reset values: ON = 0, BLINK = 0, DUTY = all ones, HALF = 1, oFpgaLights = 0, oLightReadData = 0. All counters = 0; blink phase = 1.
- Write: when iDoLedWrite = 1 at edge N, the register updates at edge N. oFpgaLights reflects the change at edge N+1 (one-cycle registered output).
- Read: when iDoLedRead = 1 at edge N, oLightReadData holds the addressed register at edge N. It holds that value until the next read.
- Simultaneous read and write to the same address: read returns the old value.
- Prescaler:
  - Counts 0..CLK_DIV-1, then wraps.
  - tick = 1 for one cycle when the count is CLK_DIV-1.
- PWM counter: PWM_BITS wide; increments every iCpuClock; free-running wrap.
- PWM gate:
  - pwm_on = 1 when DUTY is all ones.
  - Otherwise pwm_on = (pwm_cnt < DUTY).
  - DUTY = 0 means dark.
- Blink counter:
  - 16 bits; increments on tick.
  - When counter == HALF-1 and tick = 1: counter reloads to 0 and phase toggles.
  - HALF = 0 is treated as 1.
- Writing HALF clears the blink counter and sets phase = 1 on the same edge.
- Output, registered each cycle: oFpgaLights[i] = ON[i] & pwm_on & (~BLINK[i] | phase).
- Reset asserted mid-operation: all state returns to reset values immediately. No partial writes survive.

Optional Feature:
- Macro: LED_READBACK_EN.
- Defined: read path as above.
- Undefined:
  - oLightReadData is constant 0.
  - iDoLedRead is ignored.
  - No read mux is synthesised.

Test Plan:
- Reset, then write addr 0 = 16'hA5A5 and addr 1 = 16'h00FF (LED_COUNT = 24, DUTY default) -> oFpgaLights = 24'hFFA5A5 one cycle after the second write.
- DUTY = 8'h40, ON all ones -> each LED lit exactly 64 of every 256 cycles. DUTY = 0 -> all dark. DUTY = 8'hFF -> continuously lit.
- CLK_DIV = 4, HALF = 3, BLINK[0] = 1, ON[0] = 1 -> LED0 toggles every 12 cycles. LED1 with BLINK[1] = 0 stays lit.
- Write HALF mid-period -> phase = 1 on the next cycle; first toggle exactly HALF*CLK_DIV cycles later.
- With LED_READBACK_EN: write addr 1 = 16'hFFFF, then read addr 1 -> 16'h00FF (LED_COUNT = 24). Read addr 6 -> 0. Without the macro -> always 0.
- Assert iCpuReset asynchronously between clock edges while lit -> oFpgaLights = 0 before the next edge. After release, DUTY reads all ones and HALF reads 1.

Source files
------------

// File: rtl/led_pwm_driver_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | led_pwm_driver_if : MemOrIO register bus for the LED PWM driver          |
// | Revision 1.0 - initial release                                           |
// +-------------------------------------------------------------------------+
interface led_pwm_driver_if;
    logic        iDoLedWrite;
    logic        iDoLedRead;
    logic [2:0]  iLightAddress;
    logic [15:0] iLightDataToWrite;
    logic [15:0] oLightReadData;

    modport master (
        output iDoLedWrite,
        output iDoLedRead,
        output iLightAddress,
        output iLightDataToWrite,
        input  oLightReadData
    );

    modport slave (
        input  iDoLedWrite,
        input  iDoLedRead,
        input  iLightAddress,
        input  iLightDataToWrite,
        output oLightReadData
    );
endinterface
`default_nettype wire

// File: rtl/led_pwm_driver.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | led_pwm_driver : memory-mapped LED block with PWM brightness and blink.  |
// | Optional register readback enabled by macro LED_READBACK_EN.             |
// | Revision 1.0 - initial release                                           |
// +-------------------------------------------------------------------------+
module led_pwm_driver #(
    parameter int LED_COUNT = 24,
    parameter int PWM_BITS  = 8,
    parameter int CLK_DIV   = 50000
) (
    input  logic                 iCpuClock,
    input  logic                 iCpuReset,
    led_pwm_driver_if.slave      bus,
    output logic [LED_COUNT-1:0] oFpgaLights
);
    localparam int                PRE_BITS      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_BITS-1:0] PRE_LAST    = PRE_BITS'(CLK_DIV - 1);
    localparam logic [2:0]        ADDR_ON_LO    = 3'd0;
    localparam logic [2:0]        ADDR_ON_HI    = 3'd1;
    localparam logic [2:0]        ADDR_BLINK_LO = 3'd2;
    localparam logic [2:0]        ADDR_BLINK_HI = 3'd3;
    localparam logic [2:0]        ADDR_DUTY     = 3'd4;
    localparam logic [2:0]        ADDR_HALF     = 3'd5;

    logic [LED_COUNT-1:0] on_bits;
    logic [LED_COUNT-1:0] blink_bits;
    logic [PWM_BITS-1:0]  duty;
    logic [15:0]          half;
    logic [PRE_BITS-1:0]  pre_cnt;
    logic [PWM_BITS-1:0]  pwm_cnt;
    logic [15:0]          blink_cnt;
    logic                 phase;

    logic [LED_COUNT-1:0] on_sel;
    logic [LED_COUNT-1:0] blink_sel;
    logic [LED_COUNT-1:0] wr_bits;
    logic                 tick;
    logic                 pwm_on;
    logic                 half_wr;
    logic [15:0]          half_eff;

    // Each LED bit picks its half-word register and data lane at elaboration.
    for (genvar i = 0; i < LED_COUNT; i++) begin : g_led
        localparam logic [2:0] ON_ADDR    = (i < 16) ? ADDR_ON_LO : ADDR_ON_HI;
        localparam logic [2:0] BLINK_ADDR = (i < 16) ? ADDR_BLINK_LO : ADDR_BLINK_HI;
        assign on_sel[i]    = bus.iDoLedWrite && (bus.iLightAddress == ON_ADDR);
        assign blink_sel[i] = bus.iDoLedWrite && (bus.iLightAddress == BLINK_ADDR);
        assign wr_bits[i]   = bus.iLightDataToWrite[i % 16];
    end

    assign half_wr  = bus.iDoLedWrite && (bus.iLightAddress == ADDR_HALF);
    assign tick     = (pre_cnt == PRE_LAST);
    assign pwm_on   = (&duty) | (pwm_cnt < duty);
    assign half_eff = (half == 16'd0) ? 16'd1 : half;

    always_ff @(posedge iCpuClock or posedge iCpuReset) begin
        if (iCpuReset) begin
            on_bits    <= '0;
            blink_bits <= '0;
            duty       <= '1;
            half       <= 16'd1;
        end else begin
            on_bits    <= (on_bits & ~on_sel) | (wr_bits & on_sel);
            blink_bits <= (blink_bits & ~blink_sel) | (wr_bits & blink_sel);
            if (bus.iDoLedWrite && (bus.iLightAddress == ADDR_DUTY))
                duty <= PWM_BITS'(bus.iLightDataToWrite);
            if (half_wr)
                half <= bus.iLightDataToWrite;
        end
    end

    always_ff @(posedge iCpuClock or posedge iCpuReset) begin
        if (iCpuReset) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + PRE_BITS'(1);
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        end
    end

    // A HALF write restarts the blink period with the LEDs in the lit phase.
    always_ff @(posedge iCpuClock or posedge iCpuReset) begin
        if (iCpuReset) begin
            blink_cnt <= 16'd0;
            phase     <= 1'b1;
        end else if (half_wr) begin
            blink_cnt <= 16'd0;
            phase     <= 1'b1;
        end else if (tick) begin
            if (blink_cnt == half_eff - 16'd1) begin
                blink_cnt <= 16'd0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge iCpuClock or posedge iCpuReset) begin
        if (iCpuReset)
            oFpgaLights <= '0;
        else
            oFpgaLights <= on_bits & {LED_COUNT{pwm_on}} & (~blink_bits | {LED_COUNT{phase}});
    end

`ifdef LED_READBACK_EN
    logic [31:0] on_ext;
    logic [31:0] blink_ext;
    logic [15:0] rdata;

    assign on_ext    = 32'(on_bits);
    assign blink_ext = 32'(blink_bits);

    // The mux samples pre-edge register values, so a same-edge write reads old data.
    always_ff @(posedge iCpuClock or posedge iCpuReset) begin
        if (iCpuReset) begin
            rdata <= 16'd0;
        end else if (bus.iDoLedRead) begin
            case (bus.iLightAddress)
                ADDR_ON_LO:    rdata <= on_ext[15:0];
                ADDR_ON_HI:    rdata <= on_ext[31:16];
                ADDR_BLINK_LO: rdata <= blink_ext[15:0];
                ADDR_BLINK_HI: rdata <= blink_ext[31:16];
                ADDR_DUTY:     rdata <= 16'(duty);
                ADDR_HALF:     rdata <= half;
                default:       rdata <= 16'd0;
            endcase
        end
    end

    assign bus.oLightReadData = rdata;
`else
    logic unused_read;
    assign unused_read        = bus.iDoLedRead;
    assign bus.oLightReadData = 16'd0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_led_pwm_driver.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_led_pwm_driver : self-checking bench for led_pwm_driver               |
// | Revision 1.0 - initial release                                           |
// +-------------------------------------------------------------------------+
module tb_led_pwm_driver;
    localparam int N  = 24;
    localparam int D  = 4;
`ifdef LED_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] lights;

    led_pwm_driver_if bus ();

    led_pwm_driver #(.LED_COUNT(N), .PWM_BITS(8), .CLK_DIV(D)) dut (
        .iCpuClock   (clk),
        .iCpuReset   (rst),
        .bus         (bus.slave),
        .oFpgaLights (lights)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference model: architectural registers plus edge count since reset release.
    int          e;
    int          m_h;
    logic [N-1:0] m_on, m_blink;
    logic [7:0]  m_duty;
    logic [15:0] m_half, m_rd;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, e);
    endtask

    task automatic model_reset();
        e = 0; m_h = 0; m_on = '0; m_blink = '0;
        m_duty = 8'hFF; m_half = 16'd1; m_rd = 16'd0;
    endtask

    // Lights registered at edge k use the register state and counters present before edge k.
    function automatic logic [N-1:0] exp_lights(int k);
        int  hh, n;
        bit  ph, pw;
        hh = (m_half == 16'd0) ? 1 : int'(m_half);
        n  = (k - 1) / D - m_h / D;
        ph = ((n / hh) % 2) == 0;
        pw = (m_duty == 8'hFF) || (((k - 1) % 256) < int'(m_duty));
        if (!pw) return '0;
        return m_on & (~m_blink | {N{ph}});
    endfunction

    function automatic logic [15:0] rd_val(logic [2:0] a);
        logic [31:0] on32, bl32;
        on32 = 32'(m_on);
        bl32 = 32'(m_blink);
        case (a)
            3'd0: return on32[15:0];
            3'd1: return on32[31:16];
            3'd2: return bl32[15:0];
            3'd3: return bl32[31:16];
            3'd4: return {8'h00, m_duty};
            3'd5: return m_half;
            default: return 16'd0;
        endcase
    endfunction

    task automatic model_write(logic [2:0] a, logic [15:0] d);
        case (a)
            3'd0: m_on[15:0]     = d;
            3'd1: m_on[N-1:16]   = d[N-17:0];
            3'd2: m_blink[15:0]  = d;
            3'd3: m_blink[N-1:16] = d[N-17:0];
            3'd4: m_duty = d[7:0];
            3'd5: begin m_half = d; m_h = e; end
            default: ;
        endcase
    endtask

    // One bus cycle: drive at the falling edge, check after the following rising edge.
    task automatic cycle(bit we, bit re, logic [2:0] a, logic [15:0] d);
        bus.iDoLedWrite = we;
        bus.iDoLedRead = re;
        bus.iLightAddress = a;
        bus.iLightDataToWrite = d;
        @(posedge clk);
        e++;
        @(negedge clk);
        chk("lights", 32'(lights), 32'(exp_lights(e)));
        if (re && RB) m_rd = rd_val(a);
        if (we) model_write(a, d);
        chk("rdata", 32'(bus.oLightReadData), 32'(m_rd));
        bus.iDoLedWrite = 1'b0;
        bus.iDoLedRead = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.iDoLedWrite = 1'b0;
        bus.iDoLedRead = 1'b0;
        bus.iLightAddress = 3'd0;
        bus.iLightDataToWrite = 16'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [2:0]   addr;
        logic [15:0]  wdata;
        logic [15:0]  rd_exp;
        logic [N-1:0] lights_exp;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int lit;
        vecs[0] = '{3'd0, 16'hA5A5, 16'hA5A5, 24'h00A5A5};
        vecs[1] = '{3'd1, 16'h00FF, 16'h00FF, 24'hFFA5A5};
        vecs[2] = '{3'd1, 16'hFFFF, 16'h00FF, 24'hFFA5A5};
        vecs[3] = '{3'd6, 16'h1234, 16'h0000, 24'hFFA5A5};
        vecs[4] = '{3'd4, 16'h01FF, 16'h00FF, 24'hFFA5A5};
        vecs[5] = '{3'd0, 16'h0F0F, 16'h0F0F, 24'hFF0F0F};
        vecs[6] = '{3'd7, 16'hBEEF, 16'h0000, 24'hFF0F0F};

        do_reset();
        chk("reset_lights", 32'(lights), 32'd0);
        chk("reset_rdata", 32'(bus.oLightReadData), 32'd0);

        for (int i = 0; i < 7; i++) begin
            cycle(1'b1, 1'b0, vecs[i].addr, vecs[i].wdata);
            cycle(1'b0, 1'b1, vecs[i].addr, 16'd0);
            chk("vec_rdata", 32'(bus.oLightReadData), RB ? 32'(vecs[i].rd_exp) : 32'd0);
            chk("vec_lights", 32'(lights), 32'(vecs[i].lights_exp));
        end

        cycle(1'b1, 1'b1, 3'd0, 16'h5555);
        chk("rd_wr_same_addr", 32'(bus.oLightReadData), RB ? 32'h0F0F : 32'd0);

        // Duty cycle over one full PWM period.
        cycle(1'b1, 1'b0, 3'd0, 16'hFFFF);
        cycle(1'b1, 1'b0, 3'd1, 16'hFFFF);
        cycle(1'b1, 1'b0, 3'd2, 16'h0000);
        cycle(1'b1, 1'b0, 3'd3, 16'h0000);
        cycle(1'b1, 1'b0, 3'd4, 16'h0040);
        lit = 0;
        for (int k = 0; k < 256; k++) begin
            cycle(1'b0, 1'b0, 3'd0, 16'd0);
            if (lights == 24'hFFFFFF) lit++;
        end
        chk("duty40_lit_cycles", 32'(lit), 32'd64);
        cycle(1'b1, 1'b0, 3'd4, 16'h0000);
        lit = 0;
        for (int k = 0; k < 256; k++) begin
            cycle(1'b0, 1'b0, 3'd0, 16'd0);
            if (lights != 24'h0) lit++;
        end
        chk("duty00_lit_cycles", 32'(lit), 32'd0);
        cycle(1'b1, 1'b0, 3'd4, 16'h00FF);
        lit = 0;
        for (int k = 0; k < 256; k++) begin
            cycle(1'b0, 1'b0, 3'd0, 16'd0);
            if (lights == 24'hFFFFFF) lit++;
        end
        chk("dutyFF_lit_cycles", 32'(lit), 32'd256);

        // Blink: HALF written on a tick edge, so the toggle lands HALF*CLK_DIV later.
        cycle(1'b1, 1'b0, 3'd0, 16'h0003);
        cycle(1'b1, 1'b0, 3'd1, 16'h0000);
        cycle(1'b1, 1'b0, 3'd2, 16'h0001);
        while ((e % D) != D - 1) cycle(1'b0, 1'b0, 3'd0, 16'd0);
        cycle(1'b1, 1'b0, 3'd5, 16'd3);
        for (int k = 1; k <= 24; k++) begin
            cycle(1'b0, 1'b0, 3'd0, 16'd0);
            chk("blink_led0", 32'(lights[0]), (k <= 12) ? 32'd1 : 32'd0);
            chk("steady_led1", 32'(lights[1]), 32'd1);
        end

        // Random traffic against the model.
        for (int k = 0; k < 2000; k++) begin
            logic [2:0]  a;
            logic [15:0] d;
            a = 3'($urandom_range(0, 7));
            d = 16'($urandom);
            if (a == 3'd5) d = 16'($urandom_range(0, 6));
            cycle(($urandom % 3) == 0, $urandom_range(0, 1) == 1, a, d);
        end

        // Asynchronous reset between edges while lit.
        cycle(1'b1, 1'b0, 3'd0, 16'hFFFF);
        cycle(1'b1, 1'b0, 3'd1, 16'hFFFF);
        cycle(1'b1, 1'b0, 3'd2, 16'h0000);
        cycle(1'b1, 1'b0, 3'd3, 16'h0000);
        cycle(1'b1, 1'b0, 3'd4, 16'h00FF);
        cycle(1'b0, 1'b0, 3'd0, 16'd0);
        chk("lit_before_reset", 32'(lights), 32'hFFFFFF);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_lights", 32'(lights), 32'd0);
        chk("async_reset_rdata", 32'(bus.oLightReadData), 32'd0);
        do_reset();
        cycle(1'b0, 1'b1, 3'd4, 16'd0);
        chk("post_reset_duty", 32'(bus.oLightReadData), RB ? 32'h00FF : 32'd0);
        cycle(1'b0, 1'b1, 3'd5, 16'd0);
        chk("post_reset_half", 32'(bus.oLightReadData), RB ? 32'h0001 : 32'd0);
        chk("post_reset_lights", 32'(lights), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
`default_nettype wire
